// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execute-stage integer ALU:
//               operation select encoding and default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the integer datapath.
    localparam int ALU_WIDTH = 32;

    // 4-bit operation select codes driven by ALU control.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Purely combinational ALU result and zero-flag logic.
//   Ports:
//     i_a      [WIDTH-1:0]  operand A
//     i_b      [WIDTH-1:0]  operand B / shift amount (low bits only)
//     i_sel    [3:0]        operation select (alu_op_e encoding)
//     o_result [WIDTH-1:0]  operation result
//     o_zero                1 when o_result is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_sel,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    localparam int c_SHW = $clog2(WIDTH);

    // Only the low log2(WIDTH) bits of B select the shift distance.
    logic [c_SHW-1:0] w_shamt;
    logic             w_lt_signed;
    logic             w_lt_unsigned;

    assign w_shamt       = i_b[c_SHW-1:0];
    assign w_lt_signed   = $signed(i_a) < $signed(i_b);
    assign w_lt_unsigned = i_a < i_b;

    always_comb begin
        o_result = '0;
        case (i_sel)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
            // Unassigned codes yield zero so branch logic sees zero=1.
            default:  o_result = '0;
        endcase
    end

    // Zero flag covers every operation, not just SUB.
    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/riscv_alu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu
// Description : Registered integer ALU for the execute stage. Result and
//               zero flag appear one clock after the operands are sampled.
//   Ports:
//     clk                  rising-edge clock
//     reset                synchronous active-high reset
//     rd1    [WIDTH-1:0]   operand A
//     rd2    [WIDTH-1:0]   operand B / shift amount
//     sel    [3:0]         operation select
//     ALUOut [WIDTH-1:0]   registered result
//     zero                 registered flag, 1 when ALUOut is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] ALUOut,
    output logic             zero
);

    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_a      (rd1),
        .i_b      (rd2),
        .i_sel    (sel),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    // Zero is registered together with the result so the two never disagree.
    // Reset drives zero high to stay consistent with a cleared result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_result;
            r_zero   <= w_zero;
        end
    end

    assign ALUOut = r_result;
    assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_alu
// Description : Directed self-checking testbench for riscv_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [3:0]       sel;
    logic [WIDTH-1:0] ALUOut;
    logic             zero;

    int tests_run;
    int tests_failed;

    riscv_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd1    (rd1),
        .rd2    (rd2),
        .sel    (sel),
        .ALUOut (ALUOut),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, let it be captured, and sample 1 time unit later.
    task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] s);
        rd1 = a;
        rd2 = b;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(32'd7, 32'd9, 4'b0010);
        tests_run++;
        if (ALUOut !== 32'd0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_initial: ALUOut=%h zero=%b, expected 00000000 zero=1",
                     ALUOut, zero);
        end
        reset = 1'b0;
    endtask

    // One operand pair with AND/OR/ADD/SUB issued back-to-back.
    task automatic test_logic_arith(input string name,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] e_and,
                                    input logic [WIDTH-1:0] e_or,
                                    input logic [WIDTH-1:0] e_add,
                                    input logic [WIDTH-1:0] e_sub);
        logic [3:0]       ops [4];
        logic [WIDTH-1:0] exp [4];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};
        exp = '{e_and, e_or, e_add, e_sub};
        for (int i = 0; i < 4; i++) begin
            apply(a, b, ops[i]);
            tests_run++;
            if (ALUOut !== exp[i] || zero !== (exp[i] == '0)) begin
                tests_failed++;
                $display("FAIL %s sel=%b: ALUOut=%h zero=%b, expected %h zero=%b",
                         name, ops[i], ALUOut, zero, exp[i], (exp[i] == '0));
            end
        end
    endtask

    task automatic test_compare();
        logic [WIDTH-1:0] a [4];
        logic [WIDTH-1:0] b [4];
        logic [3:0]       s [4];
        logic [WIDTH-1:0] exp [4];
        a   = '{32'd50, 32'd50, 32'h8000_0000, 32'h8000_0000};
        b   = '{32'd75, 32'd75, 32'd1,         32'd1};
        s   = '{4'b1000, 4'b1001, 4'b1000,     4'b1001};
        exp = '{32'd1,  32'd1,  32'd1,         32'd0};
        for (int i = 0; i < 4; i++) begin
            apply(a[i], b[i], s[i]);
            tests_run++;
            if (ALUOut !== exp[i] || zero !== (exp[i] == '0)) begin
                tests_failed++;
                $display("FAIL compare_%0d sel=%b: ALUOut=%h zero=%b, expected %h",
                         i, s[i], ALUOut, zero, exp[i]);
            end
        end
    endtask

    task automatic test_shift_xor();
        logic [WIDTH-1:0] a [7];
        logic [WIDTH-1:0] b [7];
        logic [3:0]       s [7];
        logic [WIDTH-1:0] exp [7];
        a   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                32'h1234_5678, 32'h0000_0001, 32'hF0F0_F0F0};
        b   = '{32'd4,         32'd4,         32'd4,         32'h0000_0024,
                32'd0,         32'h0000_0021, 32'hFF00_FF00};
        s   = '{4'b0101,       4'b0111,       4'b0100,       4'b0111,
                4'b0111,       4'b0100,       4'b0011};
        exp = '{32'h0800_0000, 32'hF800_0000, 32'h0000_0000, 32'hF800_0000,
                32'h1234_5678, 32'h0000_0002, 32'h0FF0_0FF0};
        for (int i = 0; i < 7; i++) begin
            apply(a[i], b[i], s[i]);
            tests_run++;
            if (ALUOut !== exp[i] || zero !== (exp[i] == '0)) begin
                tests_failed++;
                $display("FAIL shift_xor_%0d sel=%b: ALUOut=%h zero=%b, expected %h",
                         i, s[i], ALUOut, zero, exp[i]);
            end
        end
    endtask

    task automatic test_zero_and();
        apply(32'd5, 32'd10, 4'b0000);
        tests_run++;
        if (ALUOut !== 32'd0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_and: ALUOut=%h zero=%b, expected 00000000 zero=1",
                     ALUOut, zero);
        end
    endtask

    task automatic test_undefined_sel();
        apply(32'hDEAD_BEEF, 32'h1234_5678, 4'b1111);
        tests_run++;
        if (ALUOut !== 32'd0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL undefined_sel: ALUOut=%h zero=%b, expected 00000000 zero=1",
                     ALUOut, zero);
        end
    endtask

    task automatic test_mid_reset();
        // Nonzero result first so the reset clearing it is observable.
        apply(32'd3, 32'd4, 4'b0010);
        tests_run++;
        if (ALUOut !== 32'd7 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset_add: ALUOut=%h zero=%b, expected 00000007 zero=0",
                     ALUOut, zero);
        end
        reset = 1'b1;
        apply(32'd1, 32'd1, 4'b0010);
        tests_run++;
        if (ALUOut !== 32'd0 || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: ALUOut=%h zero=%b, expected 00000000 zero=1",
                     ALUOut, zero);
        end
        reset = 1'b0;
        apply(32'd1, 32'd1, 4'b0010);
        tests_run++;
        if (ALUOut !== 32'd2 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_add: ALUOut=%h zero=%b, expected 00000002 zero=0",
                     ALUOut, zero);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        rd1   = '0;
        rd2   = '0;
        sel   = 4'b0000;
        #2;
        test_reset();
        test_logic_arith("pair_122_100", 32'd122, 32'd100,
                         32'd96, 32'd126, 32'd222, 32'd22);
        test_logic_arith("pair_50_75", 32'd50, 32'd75,
                         32'd2, 32'd123, 32'd125, 32'hFFFF_FFE7);
        test_logic_arith("pair_128_128", 32'd128, 32'd128,
                         32'd128, 32'd128, 32'd256, 32'd0);
        test_compare();
        test_shift_xor();
        test_zero_and();
        test_undefined_sel();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
